// File: rtl/field_unpack_pkg.sv
// ----------------------------------------------------------------------------
// field_unpack_pkg
//
// Purpose : shared definitions for the field unpacker slice: the FSM state
//           type and the default geometry of the packed input word.
//
// Contents: state_t          - two-state FSM encoding (IDLE, EMIT)
//           NFIELDS_D        - default number of packed fields per word
//           FW_D             - default packed field width
//           OW_D             - default emitted field width
//           SIGNED_MASK_D    - default per-field signedness mask
//           IN_W             - fixed width of the packed input word
//           IDX_W            - fixed width of the emitted field index
// ----------------------------------------------------------------------------
package field_unpack_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int NFIELDS_D = 15;
  localparam int FW_D      = 6;
  localparam int OW_D      = 8;

  localparam logic [NFIELDS_D-1:0] SIGNED_MASK_D = 15'h07F8;

  localparam int IN_W  = 128;
  localparam int IDX_W = 4;

endpackage : field_unpack_pkg

// File: rtl/field_unpacker_ext.sv
// ----------------------------------------------------------------------------
// field_ext
//
// Purpose : widen one FW-bit packed field to OW bits. Signed fields copy their
//           MSB into the new upper bits; unsigned fields get zeros. The stored
//           value itself is never shifted or altered.
//
// Ports   : din       (in,  FW) - raw packed field
//           is_signed (in,  1)  - 1 = sign-extend, 0 = zero-extend
//           dout      (out, OW) - extended field
// ----------------------------------------------------------------------------
module field_ext #(
  parameter int FW = 6,
  parameter int OW = 8
) (
  input  logic [FW-1:0] din,
  input  logic          is_signed,
  output logic [OW-1:0] dout
);

  // When OW equals FW there are no upper bits to fill, so the field passes
  // straight through and is_signed has nothing to influence.
  generate
    if (OW > FW) begin : g_extend
      logic fill;
      assign fill = is_signed & din[FW-1];
      assign dout = {{(OW-FW){fill}}, din};
    end else begin : g_pass
      logic unused_sign;
      assign unused_sign = is_signed;
      assign dout        = din;
    end
  endgenerate

endmodule : field_ext

// File: rtl/field_unpacker.sv
// ----------------------------------------------------------------------------
// field_unpacker
//
// Purpose : accept one 128-bit word holding NFIELDS packed FW-bit fields and
//           stream the fields out one per accepted cycle, each widened to OW
//           bits (sign- or zero-extended per SIGNED_MASK). Also reports
//           whether the unused upper bits of the captured word are nonzero.
//
// Ports   : clk        (in,  1)   - clock, rising edge
//           rst        (in,  1)   - synchronous active-high reset
//           in_valid   (in,  1)   - in_word is valid
//           in_ready   (out, 1)   - block accepts a word this cycle
//           in_word    (in,  128) - packed word, field i at [i*FW +: FW]
//           out_valid  (out, 1)   - current field is valid
//           out_ready  (in,  1)   - sink accepts the current field
//           out_data   (out, OW)  - extended field
//           out_idx    (out, 4)   - index of the current field
//           out_last   (out, 1)   - current field is field NFIELDS-1
//           pad_nz     (out, 1)   - unused upper bits of captured word nonzero
// ----------------------------------------------------------------------------
module field_unpacker
  import field_unpack_pkg::*;
#(
  parameter int                 NFIELDS     = NFIELDS_D,
  parameter int                 FW          = FW_D,
  parameter int                 OW          = OW_D,
  parameter logic [NFIELDS-1:0] SIGNED_MASK = SIGNED_MASK_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OW-1:0]     out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              pad_nz
);

  // Only the field region of the word is kept; the padding above it is
  // summarised into a single bit at capture time.
  localparam int                 PAYLOAD_W = NFIELDS * FW;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NFIELDS - 1);

  state_t                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   word_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   pad_q;

  logic                   accept_in;
  logic                   accept_out;
  logic                   at_last;
  logic                   pad_in;
  logic [FW-1:0]          field_sel;
  logic                   sign_sel;
  logic [OW-1:0]          field_ext_data;

  // Padding check on the incoming word. If the fields fill all 128 bits
  // there is no padding and the flag is tied off.
  generate
    if (PAYLOAD_W < IN_W) begin : g_pad
      assign pad_in = |in_word[IN_W-1:PAYLOAD_W];
    end else begin : g_nopad
      assign pad_in = 1'b0;
    end
  endgenerate

  // Next-state and handshake outputs. IDLE offers in_ready; EMIT offers
  // out_valid. Leaving EMIT only on the accepted last field gives exactly
  // one IDLE cycle between consecutive words.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && (idx_q == LAST_IDX)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign accept_in  = in_ready & in_valid;
  assign accept_out = out_valid & out_ready;
  assign at_last    = (idx_q == LAST_IDX);

  // State register. Reset wins over any handshake in the same cycle, so a
  // word in flight is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture register and field counter. The word is only written from IDLE,
  // so in_valid held high during EMIT cannot disturb it. idx stops at the
  // last field and is cleared when the word completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
      pad_q  <= 1'b0;
    end else if (accept_in) begin
      word_q <= in_word[PAYLOAD_W-1:0];
      idx_q  <= '0;
      pad_q  <= pad_in;
    end else if (accept_out) begin
      if (at_last) begin
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  // Select the current field and its signedness. Written as a compare
  // chain so an idx value beyond the last field selects nothing.
  always_comb begin
    field_sel = '0;
    sign_sel  = 1'b0;
    for (int i = 0; i < NFIELDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        field_sel = word_q[i*FW +: FW];
        sign_sel  = SIGNED_MASK[i];
      end
    end
  end

  field_ext #(
    .FW (FW),
    .OW (OW)
  ) u_field_ext (
    .din       (field_sel),
    .is_signed (sign_sel),
    .dout      (field_ext_data)
  );

  // Output qualification: everything except out_idx reads as zero outside
  // EMIT so the sink sees a quiet bus between words.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    pad_nz   = 1'b0;
    out_idx  = idx_q;
    if (state_q == EMIT) begin
      out_data = field_ext_data;
      out_last = at_last;
      pad_nz   = pad_q;
    end
  end

endmodule : field_unpacker

// File: tb/tb_field_unpacker.sv
// ----------------------------------------------------------------------------
// tb_field_unpacker
//
// Purpose : self-checking bench for field_unpacker. A reference model turns
//           every accepted word into its list of expected beats using plain
//           arithmetic; a compare process checks the DUT on every falling
//           edge against the head of that list. Directed scenarios plus a
//           randomized run drive the stimulus.
// ----------------------------------------------------------------------------
module tb_field_unpacker;

  localparam int NF   = 15;
  localparam int FWT  = 6;
  localparam int OWT  = 8;
  localparam logic [NF-1:0] MASK = 15'h07F8;

  typedef struct {
    logic [OWT-1:0] data;
    logic [3:0]     idx;
    logic           last;
    logic           pad;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [127:0]   in_word = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [OWT-1:0] out_data;
  logic [3:0]     out_idx;
  logic           out_last;
  logic           pad_nz;

  int     tests = 0;
  int     fails = 0;
  int     cyc   = 0;
  bit     chk_en   = 1'b0;
  bit     rand_rdy = 1'b0;
  beat_t  expq[$];

  logic [OWT-1:0] obs_data [NF];
  logic           obs_pad;
  int             last_beat_cyc = 0;
  int             hs_cyc        = 0;

  field_unpacker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .pad_nz    (pad_nz)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Reference: field i as an integer, negative when signed with MSB set,
  // then truncated to the output width.
  function automatic logic [OWT-1:0] modelField(input logic [127:0] w,
                                                input int i);
    int          raw;
    int          val;
    logic [31:0] tmp;
    raw = int'(w[i*FWT +: FWT]);
    val = raw;
    if (MASK[i] && raw >= (1 << (FWT-1))) val = raw - (1 << FWT);
    tmp = 32'(val);
    return tmp[OWT-1:0];
  endfunction

  function automatic logic modelPad(input logic [127:0] w);
    return (w >> (NF*FWT)) != 128'd0;
  endfunction

  task automatic pushWord(input logic [127:0] w);
    beat_t b;
    for (int i = 0; i < NF; i++) begin
      b.data = modelField(w, i);
      b.idx  = 4'(i);
      b.last = (i == NF-1);
      b.pad  = modelPad(w);
      expq.push_back(b);
    end
  endtask

  // Compare process: the model is busy exactly while beats are queued, so
  // out_valid/in_ready latency and the single bubble are checked implicitly.
  always @(negedge clk) begin
    cyc++;
    if (chk_en && !rst) begin
      checkOutput("out_valid", 32'(out_valid), 32'(expq.size() != 0));
      checkOutput("in_ready", 32'(in_ready), 32'(expq.size() == 0));
      if (expq.size() != 0) begin
        if (out_valid) begin
          checkOutput("out_data", 32'(out_data), 32'(expq[0].data));
          checkOutput("out_idx", 32'(out_idx), 32'(expq[0].idx));
          checkOutput("out_last", 32'(out_last), 32'(expq[0].last));
          checkOutput("pad_nz", 32'(pad_nz), 32'(expq[0].pad));
        end
      end else begin
        checkOutput("pad_idle", 32'(pad_nz), 32'd0);
      end
    end
    if (rst) begin
      expq.delete();
    end else begin
      if (out_valid && out_ready && expq.size() != 0) begin
        obs_data[expq[0].idx] = out_data;
        obs_pad = pad_nz;
        if (expq[0].last) last_beat_cyc = cyc;
        void'(expq.pop_front());
      end
      if (in_valid && in_ready) begin
        pushWord(in_word);
        hs_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present a word and hold it until accepted. in_valid stays high
  // afterwards when hold is set.
  task automatic applyStimulus(input logic [127:0] w, input bit hold);
    int n;
    in_valid = 1'b1;
    in_word  = w;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) checkOutput("accept_timeout", 32'(n), 32'd0);
    step();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) checkOutput("drain_timeout", 32'(n), 32'd0);
    step();
  endtask

  task automatic waitIdx(input logic [3:0] target);
    int n;
    n = 0;
    while (!(out_valid && out_idx == target) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) checkOutput("idx_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    logic [127:0] w;
    logic [127:0] w2;

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_pad_nz", 32'(pad_nz), 32'd0);
    chk_en = 1'b1;

    // Only field 0 set, sink always ready
    w = '0;
    w[5:0] = 6'b001000;
    checkOutput("model_f0", 32'(modelField(w, 0)), 32'h08);
    out_ready = 1'b1;
    applyStimulus(w, 1'b0);
    drain();
    checkOutput("beat0_data", 32'(obs_data[0]), 32'h08);
    checkOutput("beat14_data", 32'(obs_data[14]), 32'h00);
    checkOutput("word1_pad", 32'(obs_pad), 32'd0);

    // Signed field 3 and unsigned field 11 with MSB set
    w = '0;
    w[3*6 +: 6]  = 6'b111000;
    w[11*6 +: 6] = 6'b111110;
    checkOutput("model_f3", 32'(modelField(w, 3)), 32'hF8);
    checkOutput("model_f11", 32'(modelField(w, 11)), 32'h3E);
    applyStimulus(w, 1'b0);
    drain();
    checkOutput("beat3_data", 32'(obs_data[3]), 32'hF8);
    checkOutput("beat11_data", 32'(obs_data[11]), 32'h3E);

    // Stall on beat 5 for two cycles
    w = '0;
    for (int i = 0; i < NF; i++) w[i*6 +: 6] = 6'(i + 33);
    applyStimulus(w, 1'b0);
    waitIdx(4'd5);
    out_ready = 1'b0;
    step();
    checkOutput("stall1_idx", 32'(out_idx), 32'd5);
    step();
    checkOutput("stall2_idx", 32'(out_idx), 32'd5);
    out_ready = 1'b1;
    step();
    checkOutput("after_stall_idx", 32'(out_idx), 32'd6);
    drain();
    checkOutput("beat5_data", 32'(obs_data[5]), 32'(modelField(w, 5)));

    // Reset during beat 7, then a fresh word
    w = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(w, 1'b0);
    waitIdx(4'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    w[5:0] = 6'h15;
    applyStimulus(w, 1'b0);
    checkOutput("restart_idx", 32'(out_idx), 32'd0);
    drain();

    // Padding bit set, back-to-back words with in_valid held high
    w = '0;
    w[100] = 1'b1;
    w[4*6 +: 6] = 6'h2A;
    w2 = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(w, 1'b1);
    in_word = w2;
    applyStimulus(w2, 1'b0);
    checkOutput("b2b_gap", 32'(hs_cyc - last_beat_cyc), 32'd1);
    drain();

    // Randomized traffic with a randomly stalling sink
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 0) w[127:90] = '0;
      applyStimulus(w, 1'($urandom_range(0, 1)));
      in_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_field_unpacker

// File: doc/field_unpacker.md
FIELD_UNPACKER -- requirements
Module: field_unpacker

Interface
REQ-001 Parameter NFIELDS, default 15: number of packed fields per input word.
REQ-002 Parameter FW, default 6: width of each packed field.
REQ-003 Parameter OW, default 8: width of each emitted field, with OW >= FW.
REQ-004 Parameter SIGNED_MASK [NFIELDS-1:0], default 15'h07F8: bit i set means field i is signed.
REQ-005 The block SHALL have one clock, clk (input, 1): all state changes on its rising edge.
REQ-006 The block SHALL have a synchronous, active-high reset, rst (input, 1).
REQ-007 in_valid, input, 1: the input word is valid.
REQ-008 in_ready, output, 1: the block accepts a word this cycle.
REQ-009 in_word, input, 128: packed word; field i occupies bits [i*FW+FW-1 : i*FW].
REQ-010 out_valid, output, 1: the current field is valid.
REQ-011 out_ready, input, 1: the sink accepts the field.
REQ-012 out_data, output, OW: the extended field.
REQ-013 out_idx, output, 4: index of the current field.
REQ-014 out_last, output, 1: the current field is field NFIELDS-1.
REQ-015 pad_nz, output, 1: bits [127:NFIELDS*FW] of the captured word are nonzero.

Function
REQ-016 The block SHALL use an FSM with two states: IDLE and EMIT.
REQ-017 In IDLE:
- in_ready=1 and out_valid=0.
- When in_valid=1, the block captures in_word, sets idx=0, computes pad_nz, and enters EMIT on the next cycle.
REQ-018 In EMIT:
- in_ready=0 and out_valid=1.
- out_data is field idx extended to OW bits: sign-extended if SIGNED_MASK[idx]=1, zero-extended otherwise.
REQ-019 While out_valid=1 and out_ready=0, the block SHALL hold out_data, out_idx, out_last and pad_nz stable.
REQ-020 On out_valid & out_ready with idx < NFIELDS-1, idx SHALL increment by 1; one field is emitted per accepted cycle, with no bubbles.
REQ-021 On out_valid & out_ready with idx = NFIELDS-1, the FSM SHALL return to IDLE.
- in_ready=1 in the following cycle.
- Exactly one bubble cycle separates consecutive words.
REQ-022 Latency: field 0 SHALL be valid exactly 1 cycle after the input handshake.
REQ-023 Input is ignored while in EMIT; in_valid held high there SHALL NOT corrupt the captured word.
REQ-024 Extension SHALL be purely a width operation. The stored FW-bit value is never shifted, and unsigned fields never have their MSB replicated.
REQ-025 pad_nz SHALL remain valid throughout EMIT. Its value in IDLE is don't-care but is driven 0.
REQ-026 out_idx SHALL never exceed NFIELDS-1; there is no wrap to 0 inside EMIT.

Reset
REQ-027 On rst=1 at a clock edge:
- state=IDLE, idx=0, captured word=0, pad_nz=0.
- out_valid=0, in_ready=1 in the next cycle.
REQ-028 Reset mid-EMIT SHALL abandon the word with no further output. rst overrides a simultaneous handshake.

Structure
REQ-029 Shared package field_unpack_pkg SHALL hold:
- the state enum (IDLE, EMIT);
- default constants NFIELDS_D=15, FW_D=6, OW_D=8, SIGNED_MASK_D=15'h07F8.
REQ-030 One combinational sub-module, field_ext, SHALL perform the FW-to-OW sign or zero extension, parameterized by FW and OW, with input is_signed.

Verification
REQ-031 Word with field0=6'b001000, all others 0, out_ready=1 -> 15 beats on consecutive cycles; beat0 out_data=8'h08; out_last only on idx=14; pad_nz=0.
REQ-032 Field3=6'b111000 (signed) and field11=6'b111110 (unsigned) -> beat3 out_data=8'hF8; beat11 out_data=8'h3E.
REQ-033 out_ready toggled 1,0,0,1 during beat 5 -> idx=5 and out_data held stable for 3 cycles; no field is skipped or repeated.
REQ-034 rst=1 asserted during beat 7 -> next cycle out_valid=0 and in_ready=1; the next word starts at idx=0.
REQ-035 in_word bit 100 set -> pad_nz=1 for all 15 beats; back-to-back in_valid -> second word accepted exactly 1 cycle after the first word's last beat.
